inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Dual-issue instruction fetch queue that sits between the fetch stage and decode.
- Each cycle it accepts 0–2 fetched instructions, tagged with the fetch stage's issue code, and stores them in program order.
- Each cycle it presents the two oldest entries to decode.
- It returns a back-pressure `stop` to fetch and discards all contents on a branch mispredict.

Parameters:
- DEPTH, 8, number of entries; power of 2, ≥4
- PC_W, 32, PC/NPC width
- INST_W, 32, instruction width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  branch mispredict (fetch branch_flag); discard all entries
- in_issue  in  2  fetch issue code: 11 both slots, 10 slot1 only, 01 slot2 only, 00 none
- in1_pc  in  PC_W  slot1 PC
- in1_npc  in  PC_W  slot1 NPC
- in1_inst  in  INST_W  slot1 instruction
- in2_pc  in  PC_W  slot2 PC
- in2_npc  in  PC_W  slot2 NPC
- in2_inst  in  INST_W  slot2 instruction
- stop  out  1  to fetch stop; queue cannot accept a pair this cycle
- deq_cnt  in  2  entries consumed by decode this cycle (0,1,2; 3 treated as 2)
- out_valid  out  2  [1]=head valid, [0]=head+1 valid
- out1_pc, out1_npc, out1_inst  out  PC_W/PC_W/INST_W  head entry
- out2_pc, out2_npc, out2_inst  out  PC_W/PC_W/INST_W  head+1 entry

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries, each {pc, npc, inst}.
  - rd_ptr/wr_ptr are log2(DEPTH) bits and wrap mod DEPTH.
  - count is log2(DEPTH)+1 bits.
- Reset (rst=1 at posedge): rd_ptr=wr_ptr=count=0. Storage RAM is not reset. Next cycle out_valid=00, stop=0, all out_* data=0.
- stop is combinational: stop = (DEPTH-count) < 2.
  - Computed from current count only; same-cycle dequeue is ignored (conservative).
  - stop is forced 0 while flush=1.
- Enqueue fires when in_issue≠00 && !stop && !flush.
  - 11: slot1 written at wr_ptr, slot2 at wr_ptr+1; enq=2.
  - 10: slot1 written; enq=1.
  - 01: slot2 written; enq=1.
  - When enqueue is blocked by stop, nothing is written. Fetch holds its PC (stop→fetch stop), so the same pair is re-presented next cycle; no loss or duplication.
- Dequeue: deq = min(deq_cnt clamped to 2, count). rd_ptr += deq.
  - deq_cnt larger than count is legal and is clamped silently.
- Same-cycle enqueue and dequeue: count_next = count - deq + enq.
  - Entries written this cycle are visible on outputs the next cycle (enqueue-to-output latency 1).
  - No same-cycle bypass.
- Outputs are combinational reads at rd_ptr and rd_ptr+1.
  - out_valid[1] = count≥1; out_valid[0] = count≥2.
  - out_valid is forced 00 while flush=1.
  - Data of an invalid slot is driven 0.
- Flush has priority over enqueue and dequeue. At the posedge, rd_ptr=wr_ptr=count=0; an in-flight fetch pair presented in the same cycle is dropped.
- Reset has priority over flush. Reset mid-operation discards everything, identical to power-up.
- Wrap-around: a pair written at wr_ptr=DEPTH-1 places slot2 at index 0. Reading at rd_ptr=DEPTH-1 takes out2 from index 0.
- Full (count=DEPTH) with deq_cnt=2: dequeue 2, no enqueue (stop=1). Next cycle count=DEPTH-2 and stop=0.
- Empty with in_issue=11: count=2 next cycle.

Optional Feature:
- Macro: INST_QUEUE_STATS_EN.
- When defined, add output ports:
  - stat_stall_cyc (32): counts cycles with stop=1 && in_issue≠00.
  - stat_flush_cnt (32): counts cycles with flush=1.
- Both counters saturate at 32'hFFFF_FFFF and are cleared only by rst.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Fill sequence: rst, then 4 cycles in_issue=11 with pc 0,4 / 8,C / 10,14 / 18,1C and deq_cnt=0.
  - count=8, stop=1.
  - out1_pc=0, out2_pc=4, out_valid=11.
- Partial issue: empty queue, in_issue=01 pc2=0x24, then in_issue=11 pc 0x28/0x2C.
  - Outputs 0x24, 0x28; after deq_cnt=1, outputs 0x28, 0x2C.
- Full + simultaneous dequeue: count=8, in_issue=11, deq_cnt=2.
  - Input ignored, count=6.
  - Next cycle the same pair is accepted; count=8.
- Wrap: advance pointers to wr_ptr=7, enqueue pc 0x100/0x104, drain to rd_ptr=7.
  - out1_pc=0x100, out2_pc=0x104.
- Flush: count=5, flush=1 with in_issue=11 and deq_cnt=2.
  - During flush: out_valid=00, stop=0.
  - Next cycle: count=0, out_valid=00.
  - A later in_issue=11 pc 0x80/0x84 appears as the head.
- With INST_QUEUE_STATS_EN: hold full 3 cycles with in_issue=11, then flush twice.
  - stat_stall_cyc=3, stat_flush_cnt=2.
  - rst clears both to 0.

Source files
------------

// File: rtl/inst_queue.sv
// Dual-issue instruction fetch queue between fetch and decode.
// Accepts 0-2 instructions per cycle in program order and presents the two oldest to decode.
// Optional statistics counters are enabled by defining INST_QUEUE_STATS_EN.
module inst_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        in_issue,
    input  logic [PC_W-1:0]   in1_pc,
    input  logic [PC_W-1:0]   in1_npc,
    input  logic [INST_W-1:0] in1_inst,
    input  logic [PC_W-1:0]   in2_pc,
    input  logic [PC_W-1:0]   in2_npc,
    input  logic [INST_W-1:0] in2_inst,
    output logic              stop,
    input  logic [1:0]        deq_cnt,
    output logic [1:0]        out_valid,
    output logic [PC_W-1:0]   out1_pc,
    output logic [PC_W-1:0]   out1_npc,
    output logic [INST_W-1:0] out1_inst,
    output logic [PC_W-1:0]   out2_pc,
    output logic [PC_W-1:0]   out2_npc,
    output logic [INST_W-1:0] out2_inst
`ifdef INST_QUEUE_STATS_EN
    ,
    output logic [31:0]       stat_stall_cyc,
    output logic [31:0]       stat_flush_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [PC_W-1:0]   npc_mem  [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW-1:0] rd_p1, wr_p1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] free_slots;
    logic [1:0]    deq_req, deq_n, enq_n;
    logic          enq_fire;
    logic          v1, v0;

    assign rd_p1      = rd_q + AW'(1);
    assign wr_p1      = wr_q + AW'(1);
    assign free_slots = CW'(DEPTH) - cnt_q;

    // Back-pressure from current occupancy only; ignores a same-cycle dequeue on purpose.
    always_comb begin
        stop     = !flush && (free_slots < CW'(2));
        enq_fire = (in_issue != 2'b00) && !stop && !flush;
        enq_n    = 2'd0;
        if (enq_fire) begin
            enq_n = (in_issue == 2'b11) ? 2'd2 : 2'd1;
        end
    end

    // Dequeue amount: requests of 3 act as 2, then clamp to what is held.
    always_comb begin
        deq_req = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
        deq_n   = deq_req;
        if (cnt_q < CW'(deq_req)) begin
            deq_n = cnt_q[1:0];
        end
    end

    // Pointer and occupancy next state; flush empties the queue.
    always_comb begin
        rd_d  = rd_q + AW'(deq_n);
        wr_d  = wr_q + AW'(enq_n);
        cnt_d = cnt_q - CW'(deq_n) + CW'(enq_n);
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    // Pointer/occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage writes; the RAM itself is never reset.
    always_ff @(posedge clk) begin
        if (!rst && enq_fire) begin
            unique case (in_issue)
                2'b11: begin
                    pc_mem[wr_q]    <= in1_pc;
                    npc_mem[wr_q]   <= in1_npc;
                    inst_mem[wr_q]  <= in1_inst;
                    pc_mem[wr_p1]   <= in2_pc;
                    npc_mem[wr_p1]  <= in2_npc;
                    inst_mem[wr_p1] <= in2_inst;
                end
                2'b10: begin
                    pc_mem[wr_q]   <= in1_pc;
                    npc_mem[wr_q]  <= in1_npc;
                    inst_mem[wr_q] <= in1_inst;
                end
                2'b01: begin
                    pc_mem[wr_q]   <= in2_pc;
                    npc_mem[wr_q]  <= in2_npc;
                    inst_mem[wr_q] <= in2_inst;
                end
                default: ;
            endcase
        end
    end

    // Head and head+1 reads; invalid slots drive zero data.
    always_comb begin
        v1        = !flush && (cnt_q >= CW'(1));
        v0        = !flush && (cnt_q >= CW'(2));
        out_valid = {v1, v0};
        out1_pc   = '0;
        out1_npc  = '0;
        out1_inst = '0;
        out2_pc   = '0;
        out2_npc  = '0;
        out2_inst = '0;
        if (v1) begin
            out1_pc   = pc_mem[rd_q];
            out1_npc  = npc_mem[rd_q];
            out1_inst = inst_mem[rd_q];
        end
        if (v0) begin
            out2_pc   = pc_mem[rd_p1];
            out2_npc  = npc_mem[rd_p1];
            out2_inst = inst_mem[rd_p1];
        end
    end

`ifdef INST_QUEUE_STATS_EN
    // Saturating stall and flush counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cyc <= '0;
            stat_flush_cnt <= '0;
        end else begin
            if (stop && (in_issue != 2'b00) && (stat_stall_cyc != 32'hFFFF_FFFF)) begin
                stat_stall_cyc <= stat_stall_cyc + 32'd1;
            end
            if (flush && (stat_flush_cnt != 32'hFFFF_FFFF)) begin
                stat_flush_cnt <= stat_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: the driver queues the expected view of each cycle,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_inst_queue;

    localparam logic [31:0] K = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [1:0]  in_issue, deq_cnt;
    logic [31:0] in1_pc, in1_npc, in1_inst, in2_pc, in2_npc, in2_inst;
    logic        stop;
    logic [1:0]  out_valid;
    logic [31:0] out1_pc, out1_npc, out1_inst, out2_pc, out2_npc, out2_inst;
`ifdef INST_QUEUE_STATS_EN
    logic [31:0] stat_stall_cyc, stat_flush_cnt;
`endif

    typedef struct {
        logic        chk;
        logic [1:0]  v;
        logic        st;
        logic [31:0] p1;
        logic [31:0] p2;
        logic        sc;
        logic [31:0] ss;
        logic [31:0] sf;
    } exp_t;

    exp_t  sb[$];
    string nq[$];
    int    n_pass = 0;
    int    n_tot  = 0;

    inst_queue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_issue  (in_issue),
        .in1_pc    (in1_pc),
        .in1_npc   (in1_npc),
        .in1_inst  (in1_inst),
        .in2_pc    (in2_pc),
        .in2_npc   (in2_npc),
        .in2_inst  (in2_inst),
        .stop      (stop),
        .deq_cnt   (deq_cnt),
        .out_valid (out_valid),
        .out1_pc   (out1_pc),
        .out1_npc  (out1_npc),
        .out1_inst (out1_inst),
        .out2_pc   (out2_pc),
        .out2_npc  (out2_npc),
        .out2_inst (out2_inst)
`ifdef INST_QUEUE_STATS_EN
        ,
        .stat_stall_cyc (stat_stall_cyc),
        .stat_flush_cnt (stat_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end else begin
            n_pass++;
        end
    endfunction

    // Monitor: compare the DUT against the expectation queued for this cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t  e;
            string nm;
            e  = sb.pop_front();
            nm = nq.pop_front();
            if (e.chk) begin
                chk(nm, "out_valid", 32'(out_valid), 32'(e.v));
                chk(nm, "stop", 32'(stop), 32'(e.st));
                chk(nm, "out1_pc", out1_pc, e.v[1] ? e.p1 : 32'd0);
                chk(nm, "out1_npc", out1_npc, e.v[1] ? e.p1 + 32'd4 : 32'd0);
                chk(nm, "out1_inst", out1_inst, e.v[1] ? (e.p1 ^ K) : 32'd0);
                chk(nm, "out2_pc", out2_pc, e.v[0] ? e.p2 : 32'd0);
                chk(nm, "out2_npc", out2_npc, e.v[0] ? e.p2 + 32'd4 : 32'd0);
                chk(nm, "out2_inst", out2_inst, e.v[0] ? (e.p2 ^ K) : 32'd0);
`ifdef INST_QUEUE_STATS_EN
                if (e.sc) begin
                    chk(nm, "stat_stall_cyc", stat_stall_cyc, e.ss);
                    chk(nm, "stat_flush_cnt", stat_flush_cnt, e.sf);
                end
`endif
            end
        end
    end

    // Drive one cycle of stimulus and queue the outputs expected during that cycle.
    task automatic step(input logic r, input logic f, input logic [1:0] iss,
                        input logic [31:0] a, input logic [31:0] b, input logic [1:0] dq,
                        input logic c, input logic [1:0] ev, input logic es,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic sc, input logic [31:0] ss, input logic [31:0] sf,
                        input string nm);
        exp_t e;
        rst      = r;
        flush    = f;
        in_issue = iss;
        in1_pc   = a;
        in1_npc  = a + 32'd4;
        in1_inst = a ^ K;
        in2_pc   = b;
        in2_npc  = b + 32'd4;
        in2_inst = b ^ K;
        deq_cnt  = dq;
        e.chk = c;
        e.v   = ev;
        e.st  = es;
        e.p1  = e1;
        e.p2  = e2;
        e.sc  = sc;
        e.ss  = ss;
        e.sf  = sf;
        sb.push_back(e);
        nq.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_issue = 2'b00; deq_cnt = 2'd0;
        in1_pc = '0; in1_npc = '0; in1_inst = '0;
        in2_pc = '0; in2_npc = '0; in2_inst = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        // Fill from empty.
        step(0, 0, 3, 'h00, 'h04, 0, 1, 0, 0, 0, 0, 1, 0, 0, "reset_state");
        step(0, 0, 3, 'h08, 'h0C, 0, 1, 3, 0, 'h00, 'h04, 0, 0, 0, "fill_2");
        step(0, 0, 3, 'h10, 'h14, 0, 1, 3, 0, 'h00, 'h04, 0, 0, 0, "fill_4");
        step(0, 0, 3, 'h18, 'h1C, 0, 1, 3, 0, 'h00, 'h04, 0, 0, 0, "fill_6");
        step(0, 0, 0, 0, 0, 0, 1, 3, 1, 'h00, 'h04, 0, 0, 0, "fill_full");
        // Full with dequeue: pair refused, then accepted on retry.
        step(0, 0, 3, 'h20, 'h24, 2, 1, 3, 1, 'h00, 'h04, 0, 0, 0, "full_deq_blocked");
        step(0, 0, 3, 'h20, 'h24, 0, 1, 3, 0, 'h08, 'h0C, 0, 0, 0, "full_deq_retry");
        step(0, 0, 0, 0, 0, 2, 1, 3, 1, 'h08, 'h0C, 1, 1, 0, "refull");
        step(0, 0, 0, 0, 0, 2, 1, 3, 0, 'h10, 'h14, 0, 0, 0, "drain_a");
        step(0, 0, 0, 0, 0, 2, 1, 3, 0, 'h18, 'h1C, 0, 0, 0, "drain_b");
        step(0, 0, 0, 0, 0, 3, 1, 3, 0, 'h20, 'h24, 0, 0, 0, "deq3_clamp");
        step(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, "empty_over_deq");
        // Partial issue codes.
        step(0, 0, 1, 'h999, 'h24, 0, 1, 0, 0, 0, 0, 0, 0, 0, "slot2_only");
        step(0, 0, 3, 'h28, 'h2C, 0, 1, 2, 0, 'h24, 0, 0, 0, 0, "partial_head");
        step(0, 0, 0, 0, 0, 1, 1, 3, 0, 'h24, 'h28, 0, 0, 0, "partial_pair");
        step(0, 0, 0, 0, 0, 0, 1, 3, 0, 'h28, 'h2C, 0, 0, 0, "after_deq1");
        step(0, 0, 2, 'h30, 'h777, 0, 1, 3, 0, 'h28, 'h2C, 0, 0, 0, "slot1_only");
        step(0, 0, 0, 0, 0, 2, 1, 3, 0, 'h28, 'h2C, 0, 0, 0, "drain_c");
        step(0, 0, 0, 0, 0, 1, 1, 2, 0, 'h30, 0, 0, 0, 0, "slot1_head");
        // Wrap: pair written at index 7 and 0, read from rd_ptr 7.
        step(0, 0, 2, 'h50, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "to_wr7");
        step(0, 0, 3, 'h100, 'h104, 1, 1, 2, 0, 'h50, 0, 0, 0, 0, "wrap_enq");
        step(0, 0, 3, 'h200, 'h204, 0, 1, 3, 0, 'h100, 'h104, 0, 0, 0, "wrap_read");
        step(0, 0, 2, 'h208, 0, 0, 1, 3, 0, 'h100, 'h104, 0, 0, 0, "count5");
        // Flush drops contents and the in-flight pair.
        step(0, 1, 3, 'h300, 'h304, 2, 1, 0, 0, 0, 0, 0, 0, 0, "flush_out");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "post_flush");
        step(0, 0, 3, 'h80, 'h84, 0, 1, 0, 0, 0, 0, 0, 0, 0, "enq_80");
        step(0, 0, 3, 'h90, 'h94, 0, 1, 3, 0, 'h80, 'h84, 0, 0, 0, "flush_head");
        step(0, 0, 3, 'hA0, 'hA4, 0, 1, 3, 0, 'h80, 'h84, 0, 0, 0, "fill_q6");
        step(0, 0, 3, 'hB0, 'hB4, 0, 1, 3, 0, 'h80, 'h84, 0, 0, 0, "fill_q8");
        // Held full with a pending pair for three cycles.
        step(0, 0, 3, 'hC0, 'hC4, 0, 1, 3, 1, 'h80, 'h84, 1, 1, 1, "stall_1");
        step(0, 0, 3, 'hC0, 'hC4, 0, 1, 3, 1, 'h80, 'h84, 0, 0, 0, "stall_2");
        step(0, 0, 3, 'hC0, 'hC4, 0, 1, 3, 1, 'h80, 'h84, 0, 0, 0, "stall_3");
        step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 1, "flush_full_stop");
        step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 2, "flush_twice");
        step(0, 0, 3, 'hD0, 'hD4, 0, 1, 0, 0, 0, 0, 1, 4, 3, "stats_pre_rst");
        // Reset with entries held behaves like power-up.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mid");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, "rst_mid_op");
        step(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 0, "rst_idle");
        @(negedge clk);
        #1;
        n_tot++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end else begin
            n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
